uart_rx_fifo: RTL and testbench

Synthesizable 8N1 UART receiver with a small output FIFO. It is the receiving end of the serial link driven by the bench UART model (uart_bus.send_char) and by the board-side host. It sits in the peripheral subsystem and feeds received bytes to an APB-facing consumer through a valid/ready interface. Bit timing is set at runtime by a divisor input, so one instance covers every baud rate the bench uses (e.g. 781250 and 1562500 at a 25 MHz clk).

---
 rtl/uart_rx_fifo.sv | 177 +++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a small valid/ready output FIFO.
//
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   rx_i            serial line (idle high, asynchronous to clk)
//   rx_en_i         receiver enable; low aborts any frame in progress
//   divisor_i       clk cycles per bit (values below 4 behave as 4), latched per frame
//   data_o/valid_o  FIFO head byte / FIFO non-empty
//   ready_i         consumer pops the head when valid_o && ready_i
//   busy_o          frame in progress
//   frame_err_o     one-cycle pulse when the stop bit is sampled low
//   overrun_o       one-cycle pulse when a good byte is dropped on a full FIFO
//   level_o         FIFO occupancy
//
// Both error pulses are registered, so they appear in the same cycle a good
// byte would have become visible on valid_o.
module uart_rx_fifo #(
  parameter int DIV_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        rx_i,
  input  logic                        rx_en_i,
  input  logic [DIV_WIDTH-1:0]        divisor_i,
  output logic [7:0]                  data_o,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic                        busy_o,
  output logic                        frame_err_o,
  output logic                        overrun_o,
  output logic [$clog2(FIFO_DEPTH):0] level_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_e;

  // ---------------- synchronizer and edge detect ----------------
  logic       rx_meta_q, rx_s_q, rx_prev_q;
  logic [1:0] fill_q;
  logic       armed_q;
  logic       fall_w;

  // The synchronizer resets to 1, which would make a line that is already
  // low at reset release look like a falling edge. armed_q only sets once the
  // synchronizer holds real line samples and the line has been seen high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
      fill_q    <= '0;
      armed_q   <= 1'b0;
    end else begin
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
      fill_q    <= {fill_q[0], 1'b1};
      if (fill_q[1] && rx_s_q) armed_q <= 1'b1;
    end
  end

  assign fall_w = armed_q & rx_prev_q & ~rx_s_q;

  // ---------------- receive FSM ----------------
  state_e               state_q;
  logic [DIV_WIDTH-1:0] cnt_q, div_q, div_eff_w;
  logic [2:0]           bit_idx_q;
  logic [7:0]           shift_q;
  logic                 busy_q, ferr_q;
  logic                 cnt_zero_w, push_w;

  assign div_eff_w  = (divisor_i < DIV_WIDTH'(4)) ? DIV_WIDTH'(4) : divisor_i;
  assign cnt_zero_w = (cnt_q == '0);
  // Good stop bit; a disable in the same cycle wins and drops the byte.
  assign push_w     = rx_en_i && (state_q == STOP) && cnt_zero_w && rx_s_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      div_q     <= DIV_WIDTH'(4);
      bit_idx_q <= '0;
      shift_q   <= '0;
      busy_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      ferr_q <= 1'b0;
      if (!rx_en_i) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: if (fall_w) begin
            state_q <= START;
            busy_q  <= 1'b1;
            div_q   <= div_eff_w;
            cnt_q   <= (div_eff_w >> 1) - DIV_WIDTH'(1);
          end
          START: begin
            if (!cnt_zero_w) cnt_q <= cnt_q - DIV_WIDTH'(1);
            else if (rx_s_q) begin         // line back high: false start
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q   <= DATA;
              cnt_q     <= div_q - DIV_WIDTH'(1);
              bit_idx_q <= '0;
            end
          end
          DATA: begin
            if (!cnt_zero_w) cnt_q <= cnt_q - DIV_WIDTH'(1);
            else begin
              shift_q[bit_idx_q] <= rx_s_q;
              cnt_q              <= div_q - DIV_WIDTH'(1);
              bit_idx_q          <= bit_idx_q + 3'd1;
              if (bit_idx_q == 3'd7) state_q <= STOP;
            end
          end
          STOP: begin
            if (!cnt_zero_w) cnt_q <= cnt_q - DIV_WIDTH'(1);
            else if (rx_s_q) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              ferr_q  <= 1'b1;
              state_q <= BREAK;
            end
          end
          BREAK: if (rx_s_q) begin         // hold off until the line releases
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  // ---------------- output FIFO ----------------
  logic [7:0] mem_q [FIFO_DEPTH];
  logic [AW:0] wr_q, rd_q, level_w;
  logic        empty_w, full_w, pop_w, ovr_q;

  assign level_w = wr_q - rd_q;
  assign empty_w = (wr_q == rd_q);
  assign full_w  = (level_w == FULL_LVL);
  assign pop_w   = !empty_w && ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      ovr_q <= 1'b0;
    end else begin
      // A simultaneous pop frees the slot, so a full FIFO still accepts.
      if (push_w && (!full_w || pop_w)) begin
        mem_q[wr_q[AW-1:0]] <= shift_q;
        wr_q                <= wr_q + (AW+1)'(1);
      end
      if (pop_w) rd_q <= rd_q + (AW+1)'(1);
      ovr_q <= push_w && full_w && !pop_w;
    end
  end

  assign data_o      = mem_q[rd_q[AW-1:0]];
  assign valid_o     = !empty_w;
  assign level_o     = level_w;
  assign busy_o      = busy_q;
  assign frame_err_o = ferr_q;
  assign overrun_o   = ovr_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: a frame-schedule model (start edge time plus
// D/2 + k*D sample points, queue for the FIFO) checked every cycle, plus
// directed scenarios with literal expectations.
module tb_uart_rx_fifo;
  logic        clk = 1'b0;
  logic        rst_n, rx_i, rx_en_i, ready_i;
  logic [15:0] divisor_i;
  logic [7:0]  data_o;
  logic        valid_o, busy_o, frame_err_o, overrun_o;
  logic [2:0]  level_o;

  uart_rx_fifo #(.DIV_WIDTH(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .rx_i(rx_i), .rx_en_i(rx_en_i),
    .divisor_i(divisor_i), .data_o(data_o), .valid_o(valid_o),
    .ready_i(ready_i), .busy_o(busy_o), .frame_err_o(frame_err_o),
    .overrun_o(overrun_o), .level_o(level_o)
  );

  initial forever #5 clk = ~clk;

  int total = 0, bad = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- model ----------------
  // Line samples seen by the receiver arrive two clocks late; a frame starts
  // one clock after the synchronized falling edge, and is sampled at
  // t0 + D/2 + k*D for k = 0 (start), 1..8 (data), 9 (stop).
  logic [3:0]  hist;
  int          nps, off, k;
  bit          s, p, push, pop;
  bit          f_act, f_brk;
  int          f_t0, f_d;
  logic [7:0]  f_byte;
  logic [7:0]  q[$];
  bit          e_busy, e_ferr, e_ovr, prev_v;
  int          n_ferr = 0, n_ovr = 0, rise_cyc = -1;
  logic [7:0]  rise_data = 8'h0;

  initial begin
    hist = 4'hF; nps = 0; f_act = 0; f_brk = 0; f_t0 = 0; f_d = 4; f_byte = 8'h0;
    prev_v = 0;
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        nps = 0; f_act = 0; f_brk = 0; q.delete();
        e_busy = 0; e_ferr = 0; e_ovr = 0; prev_v = 0;
      end else begin
        hist = {hist[2:0], rx_i};
        if (nps < 4) nps++;
        s = hist[2]; p = hist[3];
        e_ferr = 0; e_ovr = 0; push = 0;
        if (!rx_en_i) begin
          f_act = 0; f_brk = 0;
        end else if (f_brk) begin
          if (s) f_brk = 0;
        end else if (f_act) begin
          off = cyc - f_t0 - f_d / 2;
          if (off >= 0 && off % f_d == 0) begin
            k = off / f_d;
            if (k == 0) begin
              if (s) f_act = 0;
            end else if (k <= 8) begin
              f_byte[k-1] = s;
            end else begin
              f_act = 0;
              if (s) push = 1;
              else begin e_ferr = 1; f_brk = 1; end
            end
          end
        end else if (nps >= 4 && p && !s) begin
          f_act = 1; f_t0 = cyc; f_d = (divisor_i < 4) ? 4 : int'(divisor_i);
        end
        e_busy = f_act | f_brk;
        pop = (q.size() > 0) && ready_i;
        if (push && q.size() == 4 && !pop) e_ovr = 1;
        else begin
          if (pop) void'(q.pop_front());
          if (push) q.push_back(f_byte);
        end
        #1;
        if (rst_n) begin
          chk("valid", valid_o, q.size() != 0);
          chk("level", level_o, q.size());
          if (q.size() != 0) chk("data", data_o, q[0]);
          chk("busy", busy_o, e_busy);
          chk("frame_err", frame_err_o, e_ferr);
          chk("overrun", overrun_o, e_ovr);
          if (frame_err_o === 1'b1) n_ferr++;
          if (overrun_o === 1'b1) n_ovr++;
          if (valid_o && !prev_v) begin rise_cyc = cyc; rise_data = data_o; end
          prev_v = valid_o;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  int last_p, p6, c0, c1;

  // Called at a negedge; leaves the line at the stop-bit level.
  task automatic send(input logic [7:0] b, input int d, input bit stop);
    last_p = cyc + 1;
    rx_i = 1'b0;
    repeat (d) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      repeat (d) @(negedge clk);
    end
    rx_i = stop;
    repeat (d) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_data"}, data_o, 0);
    chk({tag, "_valid"}, valid_o, 0);
    chk({tag, "_level"}, level_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_ferr"}, frame_err_o, 0);
    chk({tag, "_ovr"}, overrun_o, 0);
  endtask

  initial begin
    rst_n = 1'b0; rx_i = 1'b1; rx_en_i = 1'b1; ready_i = 1'b1; divisor_i = 16'd32;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // single byte, latency pinned: push 2 + 16 + 9*32 clocks after start
    send(8'h65, 32, 1'b1);
    repeat (4) @(negedge clk);
    chk("t1_latency", rise_cyc, last_p + 306);
    chk("t1_data", rise_data, 8'h65);
    chk("t1_level", level_o, 0);
    chk("t1_errs", n_ferr + n_ovr, 0);

    // fill and overrun
    ready_i = 1'b0;
    c0 = n_ovr;
    for (int i = 1; i <= 4; i++) send(8'(i), 32, 1'b1);
    chk("t2_no_ovr_yet", n_ovr - c0, 0);
    send(8'h05, 32, 1'b1);
    chk("t2_level", level_o, 4);
    chk("t2_ovr_once", n_ovr - c0, 1);
    ready_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("t2_pop_data", data_o, i);
      @(negedge clk);
    end
    chk("t2_drained", valid_o, 0);

    // bad stop, held-low line, recovery
    ready_i = 1'b0;
    c0 = n_ferr;
    send(8'hA5, 32, 1'b0);
    repeat (20 * 32) @(negedge clk);
    chk("t3_busy_low", busy_o, 1);
    rx_i = 1'b1;
    repeat (64) @(negedge clk);
    chk("t3_ferr_once", n_ferr - c0, 1);
    chk("t3_busy_rel", busy_o, 0);
    chk("t3_no_push", level_o, 0);
    send(8'h3C, 32, 1'b1);
    chk("t3_level", level_o, 1);
    chk("t3_data", data_o, 8'h3C);
    ready_i = 1'b1;
    repeat (3) @(negedge clk);

    // quarter-bit glitch
    c0 = n_ferr;
    rx_i = 1'b0;
    repeat (8) @(negedge clk);
    rx_i = 1'b1;
    repeat (11) @(negedge clk);
    chk("t4_busy", busy_o, 0);
    chk("t4_level", level_o, 0);
    chk("t4_noerr", n_ferr - c0, 0);

    // disable mid-frame
    ready_i = 1'b0;
    fork
      send(8'hFF, 32, 1'b1);
      begin
        repeat (5 * 32 + 16) @(negedge clk);
        chk("t5_busy_before", busy_o, 1);
        rx_en_i = 1'b0;
        @(posedge clk); #1;
        chk("t5_idle", busy_o, 0);
      end
    join
    chk("t5_no_push", level_o, 0);
    rx_en_i = 1'b1;
    repeat (10) @(negedge clk);
    send(8'h00, 32, 1'b1);
    chk("t5_level", level_o, 1);
    chk("t5_data", data_o, 8'h00);
    ready_i = 1'b1;
    repeat (3) @(negedge clk);

    // divisor change mid-frame affects only the next frame
    ready_i = 1'b0;
    fork
      send(8'hC3, 32, 1'b1);
      begin repeat (100) @(negedge clk); divisor_i = 16'd16; end
    join
    repeat (4) @(negedge clk);
    send(8'h5A, 16, 1'b1);
    chk("t5d_level", level_o, 2);
    chk("t5d_first", data_o, 8'hC3);
    ready_i = 1'b1;
    @(negedge clk);
    chk("t5d_second", data_o, 8'h5A);
    repeat (3) @(negedge clk);

    // full FIFO, pop lands on the stop-sample cycle
    ready_i = 1'b0;
    for (int i = 0; i < 4; i++) send(8'h11 + 8'(i), 16, 1'b1);
    chk("t6_full", level_o, 4);
    c1 = n_ovr;
    p6 = cyc + 1;
    fork
      send(8'h99, 16, 1'b1);
      begin
        while (cyc < p6 + 153) @(negedge clk);
        ready_i = 1'b1;
        @(posedge clk); #1;
        chk("t6_level_same", level_o, 4);
        chk("t6_no_ovr", overrun_o, 0);
        chk("t6_head", data_o, 8'h12);
        repeat (3) @(posedge clk); #1;
        chk("t6_last", data_o, 8'h99);
        chk("t6_last_lvl", level_o, 1);
      end
    join
    chk("t6_ovr_total", n_ovr - c1, 0);
    chk("t6_empty", valid_o, 0);

    // divisor below minimum behaves as 4
    divisor_i = 16'd2;
    repeat (4) @(negedge clk);
    send(8'h96, 4, 1'b1);
    repeat (4) @(negedge clk);
    chk("clamp_latency", rise_cyc, last_p + 40);
    chk("clamp_data", rise_data, 8'h96);
    divisor_i = 16'd16;

    // asynchronous reset mid-frame with a byte held in the FIFO
    ready_i = 1'b0;
    send(8'h77, 16, 1'b1);
    chk("rst_pre_valid", valid_o, 1);
    rx_i = 1'b0;
    repeat (40) @(negedge clk);
    chk("rst_pre_busy", busy_o, 1);
    #3 rst_n = 1'b0;
    #1 chk_all_zero("async_rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("rst_low_line", busy_o, 0);
    rx_i = 1'b1;
    repeat (10) @(negedge clk);
    ready_i = 1'b1;
    send(8'h5A, 16, 1'b1);
    repeat (4) @(negedge clk);
    chk("rst_recover", rise_data, 8'h5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
